// File: rtl/msg_transmitter_pkg.sv
// Shared protocol definitions for the response transmitter: header geometry,
// protocol version, command codes and a header packing helper.
package msg_transmitter_pkg;

  localparam int SIZE_OF_HEADER_VARS     = 8;
  localparam int SIZE_OF_HEADER_IN_BYTES = 4;

  localparam logic [SIZE_OF_HEADER_VARS-1:0] PROTOCOL_VERSION = 8'h10;

  typedef enum logic [SIZE_OF_HEADER_VARS-1:0] {
    CMD_PING   = 8'h01,
    CMD_READ   = 8'h20,
    CMD_WRITE  = 8'h21,
    CMD_STATUS = 8'h7F
  } cmd_t;

  function automatic logic [SIZE_OF_HEADER_IN_BYTES*SIZE_OF_HEADER_VARS-1:0] make_header(
    input logic [SIZE_OF_HEADER_VARS-1:0] version,
    input cmd_t                           command,
    input logic [SIZE_OF_HEADER_VARS-1:0] param1,
    input logic [SIZE_OF_HEADER_VARS-1:0] param2
  );
    return {version, command, param1, param2};
  endfunction

endpackage

// File: rtl/msg_transmitter_if.sv
// Bundle of the builder-side inputs, payload-buffer port and byte-sink port
// of the transmitter. The slave modport is the transmitter itself.
interface msg_transmitter_if
  import msg_transmitter_pkg::*;
#(
  parameter int HDR_BYTES = SIZE_OF_HEADER_IN_BYTES,
  parameter int BYTE_W    = SIZE_OF_HEADER_VARS
);
  logic [HDR_BYTES*BYTE_W-1:0] header;
  logic                        MSG_ready;
  logic [7:0]                  Payload_len;
  logic [BYTE_W-1:0]           Payload_byte;
  logic                        Abort;
  logic                        TX_ready;
  logic                        Payload_rd;
  logic [7:0]                  Payload_addr;
  logic [BYTE_W-1:0]           TX_byte;
  logic                        TX_valid;
  logic                        TX_last;
  logic                        Busy;
  logic                        MSG_sent;

  modport slave (
    input  header, MSG_ready, Payload_len, Payload_byte, Abort, TX_ready,
    output Payload_rd, Payload_addr, TX_byte, TX_valid, TX_last, Busy, MSG_sent
  );

  modport master (
    output header, MSG_ready, Payload_len, Payload_byte, Abort, TX_ready,
    input  Payload_rd, Payload_addr, TX_byte, TX_valid, TX_last, Busy, MSG_sent
  );
endinterface

// File: rtl/msg_transmitter.sv
// Serialises a captured response header (MSB byte first) followed by an
// optional payload read from an external buffer, onto a valid/ready byte sink.
module msg_transmitter
  import msg_transmitter_pkg::*;
#(
  parameter int HDR_BYTES = SIZE_OF_HEADER_IN_BYTES,
  parameter int BYTE_W    = SIZE_OF_HEADER_VARS
)(
  input  logic              clk,
  input  logic              reset,
  msg_transmitter_if.slave  bus
);

  localparam int CNT_W = (HDR_BYTES > 1) ? $clog2(HDR_BYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_HDR = CNT_W'(HDR_BYTES - 1);

  typedef enum logic [2:0] {IDLE, SEND_HDR, FETCH_PL, SEND_PL, DONE} state_t;

  state_t                      state_reg, state_next;
  logic [HDR_BYTES*BYTE_W-1:0] hdr_reg, hdr_next;
  logic [7:0]                  len_reg, len_next;
  logic [CNT_W-1:0]            cnt_reg, cnt_next;
  logic [7:0]                  addr_reg, addr_next;
  logic [BYTE_W-1:0]           pl_reg, pl_next;
  logic                        pl_hold_reg, pl_hold_next;
  logic                        armed_reg, armed_next;

  logic                        start;
  logic                        xfer;
  logic                        tx_valid;
  logic [BYTE_W-1:0]           hdr_bytes [HDR_BYTES];

  for (genvar gi = 0; gi < HDR_BYTES; gi++) begin : g_hdr
    assign hdr_bytes[gi] = hdr_reg[(HDR_BYTES-1-gi)*BYTE_W +: BYTE_W];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      hdr_reg     <= '0;
      len_reg     <= '0;
      cnt_reg     <= '0;
      addr_reg    <= '0;
      pl_reg      <= '0;
      pl_hold_reg <= 1'b0;
      armed_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      hdr_reg     <= hdr_next;
      len_reg     <= len_next;
      cnt_reg     <= cnt_next;
      addr_reg    <= addr_next;
      pl_reg      <= pl_next;
      pl_hold_reg <= pl_hold_next;
      armed_reg   <= armed_next;
    end
  end

  // armed_reg records that MSG_ready was seen low while idle, so only a fresh
  // rising edge can start a message (also after reset or an abort).
  assign start    = armed_reg && bus.MSG_ready;
  assign tx_valid = (state_reg == SEND_HDR) || (state_reg == SEND_PL);
  assign xfer     = tx_valid && bus.TX_ready;

  always_comb begin
    state_next   = state_reg;
    hdr_next     = hdr_reg;
    len_next     = len_reg;
    cnt_next     = cnt_reg;
    addr_next    = addr_reg;
    pl_next      = pl_reg;
    pl_hold_next = pl_hold_reg;
    armed_next   = armed_reg;

    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = SEND_HDR;
          hdr_next   = bus.header;
          len_next   = bus.Payload_len;
          cnt_next   = '0;
          addr_next  = '0;
          armed_next = 1'b0;
        end else if (!bus.MSG_ready) begin
          armed_next = 1'b1;
        end
      end
      SEND_HDR: begin
        if (xfer) begin
          if (cnt_reg == LAST_HDR) begin
            state_next = (len_reg == 8'd0) ? DONE : FETCH_PL;
            addr_next  = '0;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end
      FETCH_PL: begin
        state_next   = SEND_PL;
        pl_hold_next = 1'b0;
      end
      SEND_PL: begin
        // Read data is only guaranteed in the first SEND_PL cycle; keep a copy
        // so the byte stays stable across a stall.
        if (!pl_hold_reg) begin
          pl_next      = bus.Payload_byte;
          pl_hold_next = 1'b1;
        end
        if (xfer) begin
          if (addr_reg == len_reg - 8'd1) begin
            state_next = DONE;
          end else begin
            addr_next  = addr_reg + 8'd1;
            state_next = FETCH_PL;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
        if (!bus.MSG_ready) armed_next = 1'b1;
      end
      default: state_next = IDLE;
    endcase

    if (state_reg != IDLE && bus.Abort) state_next = IDLE;
  end

  always_comb begin
    bus.TX_byte = '0;
    if (state_reg == SEND_HDR)     bus.TX_byte = hdr_bytes[cnt_reg];
    else if (state_reg == SEND_PL) bus.TX_byte = pl_hold_reg ? pl_reg : bus.Payload_byte;
  end

  assign bus.TX_valid     = tx_valid;
  assign bus.TX_last      = ((state_reg == SEND_HDR) && (cnt_reg == LAST_HDR) && (len_reg == 8'd0)) ||
                            ((state_reg == SEND_PL) && (addr_reg == len_reg - 8'd1));
  assign bus.Busy         = (state_reg == SEND_HDR) || (state_reg == FETCH_PL) || (state_reg == SEND_PL);
  assign bus.MSG_sent     = (state_reg == DONE);
  assign bus.Payload_rd   = (state_reg == FETCH_PL);
  assign bus.Payload_addr = addr_reg;

endmodule

// File: tb/tb_msg_transmitter.sv
// Directed bench for msg_transmitter: header-only, stalls, payload, held
// MSG_ready, abort, mid-message reset and a 255-byte payload.
module tb_msg_transmitter;
  import msg_transmitter_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;
  int   sent_cnt = 0;
  int   valid_cnt = 0;
  logic [7:0] got_b [$];
  logic       got_l [$];
  logic [7:0] got_a [$];
  logic [7:0] exp_b [$];
  logic [7:0] mem [256];
  logic [7:0] pb;
  logic       stall_prev;
  logic [7:0] prev_b;
  logic       prev_l;

  msg_transmitter_if #(.HDR_BYTES(4), .BYTE_W(8)) bus ();

  msg_transmitter #(.HDR_BYTES(4), .BYTE_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // External payload buffer: registered read, data valid one cycle after Payload_rd.
  always @(posedge clk) if (bus.Payload_rd) pb <= mem[bus.Payload_addr];
  assign bus.Payload_byte = pb;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.TX_valid && bus.TX_ready) begin
        got_b.push_back(bus.TX_byte);
        got_l.push_back(bus.TX_last);
      end
      if (bus.Payload_rd) got_a.push_back(bus.Payload_addr);
      if (bus.MSG_sent) sent_cnt++;
      if (bus.TX_valid) valid_cnt++;
      if (stall_prev && bus.TX_valid) begin
        check("stall_byte", {24'h0, bus.TX_byte}, {24'h0, prev_b});
        check("stall_last", {31'h0, bus.TX_last}, {31'h0, prev_l});
      end
      stall_prev = bus.TX_valid && !bus.TX_ready;
      prev_b     = bus.TX_byte;
      prev_l     = bus.TX_last;
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_capture();
    got_b.delete();
    got_l.delete();
    got_a.delete();
  endtask

  task automatic run_until_sent(input string tag, input int max_ticks);
    int s = sent_cnt;
    int k = 0;
    while (sent_cnt == s && k < max_ticks) begin
      tick();
      k++;
    end
    check({tag, "_sent"}, sent_cnt - s, 1);
    $display("msg %s: %0d bytes out, %0d payload reads, %0d cycles", tag, got_b.size(), got_a.size(), k);
  endtask

  task automatic check_stream(input string tag);
    check({tag, "_count"}, got_b.size(), exp_b.size());
    for (int i = 0; i < exp_b.size() && i < got_b.size(); i++) begin
      check($sformatf("%s_byte%0d", tag, i), {24'h0, got_b[i]}, {24'h0, exp_b[i]});
      check($sformatf("%s_last%0d", tag, i), {31'h0, got_l[i]}, {31'h0, i == exp_b.size() - 1});
    end
  endtask

  // Drop MSG_ready for one edge, then raise it with the given header/length.
  task automatic launch(input logic [31:0] hdr, input logic [7:0] len);
    bus.MSG_ready = 1'b0;
    tick();
    clear_capture();
    bus.header      = hdr;
    bus.Payload_len = len;
    bus.MSG_ready   = 1'b1;
  endtask

  initial begin
    int v0;
    int s0;
    logic [1:0] rdy_pat;
    reset            = 1'b1;
    bus.header       = '0;
    bus.MSG_ready    = 1'b0;
    bus.Payload_len  = '0;
    bus.Abort        = 1'b0;
    bus.TX_ready     = 1'b0;
    stall_prev       = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;

    // Reset state, before any clock edge
    #3;
    check("rst_valid", {31'h0, bus.TX_valid}, 0);
    check("rst_busy",  {31'h0, bus.Busy}, 0);
    check("rst_sent",  {31'h0, bus.MSG_sent}, 0);
    check("rst_rd",    {31'h0, bus.Payload_rd}, 0);
    check("rst_addr",  {24'h0, bus.Payload_addr}, 0);
    check("rst_byte",  {24'h0, bus.TX_byte}, 0);
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;

    // Header only, TX_ready high: one byte per cycle, 1-cycle latency
    bus.TX_ready = 1'b1;
    launch(make_header(PROTOCOL_VERSION, CMD_STATUS, 8'h01, 8'h00), 8'd0);
    check("h0_idle_busy", {31'h0, bus.Busy}, 0);
    tick();
    check("h0_b0_valid", {31'h0, bus.TX_valid}, 1);
    check("h0_b0_busy",  {31'h0, bus.Busy}, 1);
    check("h0_b0",       {24'h0, bus.TX_byte}, 32'h10);
    check("h0_b0_last",  {31'h0, bus.TX_last}, 0);
    tick();
    check("h0_b1", {24'h0, bus.TX_byte}, 32'h7F);
    tick();
    check("h0_b2", {24'h0, bus.TX_byte}, 32'h01);
    tick();
    check("h0_b3",      {24'h0, bus.TX_byte}, 32'h00);
    check("h0_b3_last", {31'h0, bus.TX_last}, 1);
    tick();
    check("h0_done_sent",  {31'h0, bus.MSG_sent}, 1);
    check("h0_done_busy",  {31'h0, bus.Busy}, 0);
    check("h0_done_valid", {31'h0, bus.TX_valid}, 0);
    tick();
    check("h0_idle_sent", {31'h0, bus.MSG_sent}, 0);
    exp_b = '{8'h10, 8'h7F, 8'h01, 8'h00};
    check_stream("h0");
    $display("msg h0: %0d bytes out", got_b.size());

    // MSG_ready held high: no second message
    v0 = valid_cnt;
    repeat (20) tick();
    check("held_sent_total", sent_cnt, 1);
    check("held_no_valid", valid_cnt - v0, 0);

    // TX_ready toggled 1,0,0,1: nothing lost or duplicated
    launch(32'h107F0100, 8'd0);
    begin
      int k = 0;
      s0 = sent_cnt;
      while (sent_cnt == s0 && k < 40) begin
        case (k % 4)
          0: rdy_pat = 2'b01;
          1: rdy_pat = 2'b00;
          2: rdy_pat = 2'b00;
          default: rdy_pat = 2'b01;
        endcase
        bus.TX_ready = rdy_pat[0];
        tick();
        k++;
      end
      check("stall_sent", sent_cnt - s0, 1);
      $display("msg stall: %0d bytes out in %0d cycles", got_b.size(), k);
    end
    check_stream("stall");
    bus.TX_ready = 1'b1;

    // Payload of 3 bytes; header/len changes while busy are ignored
    mem[0] = 8'hA1; mem[1] = 8'hB2; mem[2] = 8'hC3;
    launch(32'h1020AB03, 8'd3);
    tick();
    bus.header      = 32'hFFFFFFFF;
    bus.Payload_len = 8'd9;
    run_until_sent("pl3", 40);
    exp_b = '{8'h10, 8'h20, 8'hAB, 8'h03, 8'hA1, 8'hB2, 8'hC3};
    check_stream("pl3");
    check("pl3_rd_count", got_a.size(), 3);
    for (int i = 0; i < 3 && i < got_a.size(); i++)
      check($sformatf("pl3_rd_addr%0d", i), {24'h0, got_a[i]}, i);

    // Abort during payload byte 1 of 3
    launch(32'h1020AB03, 8'd3);
    begin
      int k = 0;
      while (!(bus.TX_valid && bus.Payload_addr == 8'd1) && k < 30) begin
        tick();
        k++;
      end
      check("abort_reach_pl1", {31'h0, bus.TX_valid && bus.Payload_addr == 8'd1}, 1);
    end
    s0 = sent_cnt;
    bus.Abort = 1'b1;
    tick();
    bus.Abort = 1'b0;
    check("abort_valid", {31'h0, bus.TX_valid}, 0);
    check("abort_busy",  {31'h0, bus.Busy}, 0);
    check("abort_rd",    {31'h0, bus.Payload_rd}, 0);
    check("abort_sent",  {31'h0, bus.MSG_sent}, 0);
    v0 = valid_cnt;
    repeat (5) tick();
    check("abort_no_sent",    sent_cnt - s0, 0);
    check("abort_no_restart", valid_cnt - v0, 0);
    $display("msg abort: %0d bytes out before abort", got_b.size());

    // Abort in IDLE coincident with MSG_ready rise does not block the start
    launch(32'h1020AB03, 8'd3);
    bus.Abort = 1'b1;
    tick();
    bus.Abort = 1'b0;
    check("idle_abort_start", {31'h0, bus.TX_valid}, 1);
    run_until_sent("after_abort", 40);
    check_stream("after_abort");

    // Reset during header byte 2
    launch(32'hC0FFEE11, 8'd0);
    repeat (3) tick();
    check("rst_mid_pre_byte", {24'h0, bus.TX_byte}, 32'hEE);
    reset = 1'b1;
    #1;
    check("rst_mid_valid", {31'h0, bus.TX_valid}, 0);
    check("rst_mid_busy",  {31'h0, bus.Busy}, 0);
    check("rst_mid_byte",  {24'h0, bus.TX_byte}, 0);
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
    v0 = valid_cnt;
    s0 = sent_cnt;
    repeat (10) tick();
    check("rst_no_resume", valid_cnt - v0, 0);
    check("rst_no_sent",   sent_cnt - s0, 0);
    check("rst_idle_busy", {31'h0, bus.Busy}, 0);
    launch(32'hC0FFEE11, 8'd0);
    run_until_sent("after_rst", 20);
    exp_b = '{8'hC0, 8'hFF, 8'hEE, 8'h11};
    check_stream("after_rst");

    // Maximum payload length: 255 bytes, addresses 0..254
    for (int i = 0; i < 255; i++) mem[i] = 8'(i) ^ 8'h5A;
    launch(32'h107F02FF, 8'd255);
    run_until_sent("pl255", 700);
    exp_b = '{8'h10, 8'h7F, 8'h02, 8'hFF};
    for (int i = 0; i < 255; i++) exp_b.push_back(8'(i) ^ 8'h5A);
    check_stream("pl255");
    check("pl255_rd_count", got_a.size(), 255);
    if (got_a.size() > 0) check("pl255_rd_lastaddr", {24'h0, got_a[got_a.size()-1]}, 254);
    check("pl255_addr_end", {24'h0, bus.Payload_addr}, 254);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
